alu_cmd_seq: RTL

- Sequential command initiator for the team's 4-bit combinational ALU (opcode-selected add/sub/logic/compare with zero/overflow/carry flags).
- Accepts operation commands over a valid/ready handshake and drives the ALU's operand and opcode inputs.
- Samples the ALU result and flags after a settle window and returns them over a second valid/ready handshake.
- Also keeps an accumulator for chained operations, a sticky overflow flag, and a saturating operation counter.

---
 rtl/alu_cmd_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: sequential command initiator for the 4-bit combinational ALU.
// Accepts a command over valid/ready, holds the ALU inputs for a settle
// window, captures result and flags, and returns them over a second
// valid/ready handshake. Also keeps a chaining accumulator, a sticky
// overflow flag and a saturating count of completed responses.
module alu_cmd_seq #(
  parameter int SETTLE_CYC = 1,  // ISSUE cycles before sampling, legal 1..7
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_acc,
  // ALU drive / sample
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ch,
  input  logic [3:0]       alu_f,
  input  logic             alu_zero,
  input  logic             alu_over,
  input  logic             alu_cout,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_f,
  output logic             rsp_zero,
  output logic             rsp_over,
  output logic             rsp_cout,
  // status
  output logic [3:0]       acc,
  output logic             sticky_over,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [2:0]       SETTLE_LOAD = 3'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0] state;
  logic [2:0] settle_cnt;
  logic       cmd_fire;
  logic       rsp_fire;
  logic       capture;
  logic       is_compare;

  // Handshake flags decode straight from the state register.
  // NOTE: plain continuous assigns of complete expressions cannot infer a
  // latch; any always_comb would need a default for every output first.
  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign capture    = (state == ISSUE) && (settle_cnt == 3'd0);
  // Compare opcodes (110, 111) return a flag in bit 0, not a chainable value.
  assign is_compare = (alu_ch[2:1] == 2'b11);

  // Sequencer: IDLE -> ISSUE (settle countdown) -> RESP -> IDLE.
  // NOTE: every clocked register uses non-blocking assignment so all flops
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            state      <= ISSUE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        ISSUE: begin
          if (settle_cnt == 3'd0) begin
            state <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU operand/opcode registers: loaded on command accept, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= 4'd0;
      alu_b  <= 4'd0;
      alu_ch <= 3'd0;
    end else if (cmd_fire) begin
      alu_a  <= cmd_acc ? acc : cmd_a;
      alu_b  <= cmd_b;
      alu_ch <= cmd_op;
    end
  end

  // Response registers: sample the ALU at the end of the settle window.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_f    <= 4'd0;
      rsp_zero <= 1'b0;
      rsp_over <= 1'b0;
      rsp_cout <= 1'b0;
    end else if (capture) begin
      rsp_f    <= alu_f;
      rsp_zero <= alu_zero;
      rsp_over <= alu_over;
      rsp_cout <= alu_cout;
    end
  end

  // Accumulator follows arithmetic/logic results, skips compares.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 4'd0;
    end else if (capture && !is_compare) begin
      acc <= alu_f;
    end
  end

  // Sticky overflow: a new overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_over <= 1'b0;
    end else if (capture && alu_over) begin
      sticky_over <= 1'b1;
    end else if (clr_sticky) begin
      sticky_over <= 1'b0;
    end
  end

  // Completed-response counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (rsp_fire && (op_cnt != CNT_MAX)) begin
      op_cnt <= op_cnt + CNT_ONE;
    end
  end

endmodule
